// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM state encoding and default width for the ALU sequencer
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_XOR = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INV  = 2'd1,
      EXEC = 2'd2,
      RESP = 2'd3
   } state_e;

endpackage

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - combinational adder/logic datapath with zero, sign and overflow flags
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b_eff,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   logic [WIDTH-1:0] sum;

   // Shared adder serves both ADD and SUB; for SUB b_eff is already ~b and cin is 1,
   // so the overflow test compares a against the inverted operand. Carry out is dropped.
   always_comb begin
      sum    = a + b_eff + {{(WIDTH-1){1'b0}}, cin};
      result = sum;
      of     = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            result = sum;
            of     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: result = a & b_eff;
         OP_XOR: result = a ^ b_eff;
         default: result = sum;
      endcase
      zf = (result == '0);
      sf = result[WIDTH-1];
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU controller with valid/ready request and response channels
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zf,
   output logic             rsp_sf,
   output logic             rsp_of,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_INV  = INV;
   localparam logic [1:0] S_EXEC = EXEC;
   localparam logic [1:0] S_RESP = RESP;

   logic [1:0]       state_q,  state_d;
   logic [1:0]       op_q,     op_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic             cin_q,    cin_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zf_q,     zf_d;
   logic             sf_q,     sf_d;
   logic             of_q,     of_d;

   logic [WIDTH-1:0] ex_result;
   logic             ex_zf;
   logic             ex_sf;
   logic             ex_of;

   alu_exec_unit #(
      .WIDTH (WIDTH)
   ) u_exec (
      .op     (op_q),
      .a      (a_q),
      .b_eff  (b_q),
      .cin    (cin_q),
      .result (ex_result),
      .zf     (ex_zf),
      .sf     (ex_sf),
      .of     (ex_of)
   );

   // Handshake outputs depend on state only, never on the incoming valid
   always_comb begin
      req_ready  = (state_q == S_IDLE) && !rst;
      rsp_valid  = (state_q == S_RESP);
      busy       = (state_q != S_IDLE);
      rsp_result = result_q;
      rsp_zf     = zf_q;
      rsp_sf     = sf_q;
      rsp_of     = of_q;
   end

   // Next-state and datapath register updates for the IDLE/INV/EXEC/RESP sequence
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cin_d    = cin_q;
      result_d = result_q;
      zf_d     = zf_q;
      sf_d     = sf_q;
      of_d     = of_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               op_d    = req_op;
               a_d     = req_a;
               b_d     = req_b;
               cin_d   = 1'b0;
               state_d = (req_op == OP_SUB) ? S_INV : S_EXEC;
            end
         end
         S_INV: begin
            // Subtract as a + ~b + 1 on the shared adder
            b_d     = ~b_q;
            cin_d   = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            result_d = ex_result;
            zf_d     = ex_zf;
            sf_d     = ex_sf;
            of_d     = ex_of;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath flops; reset aborts any op in flight and clears the result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= 2'd0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         result_q <= '0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         result_q <= result_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
         of_q     <= of_d;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zf;
   logic        rsp_sf;
   logic        rsp_of;
   logic        busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_op_sequencer #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zf     (rsp_zf),
      .rsp_sf     (rsp_sf),
      .rsp_of     (rsp_of),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with rsp_ready high; returns captured response and latency in cycles
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [2:0] flags, output int lat);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      step();
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         step();
         lat++;
      end
      res   = rsp_result;
      flags = {rsp_zf, rsp_sf, rsp_of};
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      req_op = 2'd0;
      req_a = 32'd0;
      req_b = 32'd0;
      repeat (3) step();
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%0b exp=0", req_ready); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass_cnt++;
      total_cnt++; if ({rsp_result, rsp_zf, rsp_sf, rsp_of} !== 35'd0)
         $display("FAIL reset_outputs got=%h/%b%b%b exp=0", rsp_result, rsp_zf, rsp_sf, rsp_of); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%0b exp=1", req_ready); else pass_cnt++;
      step();
   endtask

   task automatic test_add();
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      run_op(2'd0, 32'd5, 32'd3, res, fl, lat);
      total_cnt++; if (res !== 32'd8) $display("FAIL add_result got=%h exp=00000008", res); else pass_cnt++;
      total_cnt++; if (fl !== 3'b000) $display("FAIL add_flags got=%b exp=000", fl); else pass_cnt++;
      total_cnt++; if (lat !== 2) $display("FAIL add_latency got=%0d exp=2", lat); else pass_cnt++;
      total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_width got=%0b exp=0", rsp_valid); else pass_cnt++;
   endtask

   task automatic test_sub();
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op = 2'd1;
      req_a = 32'd3;
      req_b = 32'd5;
      step();
      req_valid = 1'b0;
      total_cnt++; if ({busy, rsp_valid, req_ready} !== 3'b100)
         $display("FAIL sub_inv_status got=%b exp=100", {busy, rsp_valid, req_ready}); else pass_cnt++;
      step();
      total_cnt++; if ({busy, rsp_valid, req_ready} !== 3'b100)
         $display("FAIL sub_exec_status got=%b exp=100", {busy, rsp_valid, req_ready}); else pass_cnt++;
      step();
      total_cnt++; if ({busy, rsp_valid} !== 2'b11) $display("FAIL sub_resp_status got=%b exp=11", {busy, rsp_valid}); else pass_cnt++;
      total_cnt++; if (rsp_result !== 32'hFFFF_FFFE) $display("FAIL sub_result got=%h exp=fffffffe", rsp_result); else pass_cnt++;
      total_cnt++; if ({rsp_zf, rsp_sf, rsp_of} !== 3'b010)
         $display("FAIL sub_flags got=%b exp=010", {rsp_zf, rsp_sf, rsp_of}); else pass_cnt++;
      step();
      total_cnt++; if ({busy, rsp_valid, req_ready} !== 3'b001)
         $display("FAIL sub_return_idle got=%b exp=001", {busy, rsp_valid, req_ready}); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      run_op(2'd0, 32'h7FFF_FFFF, 32'd1, res, fl, lat);
      total_cnt++; if (res !== 32'h8000_0000) $display("FAIL ovf_add_result got=%h exp=80000000", res); else pass_cnt++;
      total_cnt++; if (fl !== 3'b011) $display("FAIL ovf_add_flags got=%b exp=011", fl); else pass_cnt++;
      run_op(2'd1, 32'h8000_0000, 32'd1, res, fl, lat);
      total_cnt++; if (res !== 32'h7FFF_FFFF) $display("FAIL ovf_sub_result got=%h exp=7fffffff", res); else pass_cnt++;
      total_cnt++; if (fl !== 3'b001) $display("FAIL ovf_sub_flags got=%b exp=001", fl); else pass_cnt++;
      total_cnt++; if (lat !== 3) $display("FAIL ovf_sub_latency got=%0d exp=3", lat); else pass_cnt++;
      run_op(2'd1, 32'd5, 32'd5, res, fl, lat);
      total_cnt++; if (res !== 32'd0) $display("FAIL sub_zero_result got=%h exp=00000000", res); else pass_cnt++;
      total_cnt++; if (fl !== 3'b100) $display("FAIL sub_zero_flags got=%b exp=100", fl); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int cnt;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_op = 2'd3;
      req_a = 32'hA5A5_A5A5;
      req_b = 32'hA5A5_A5A5;
      step();
      req_op = 2'd0;
      req_a = 32'd2;
      req_b = 32'd2;
      cnt = 1;
      while (!rsp_valid && cnt < 20) begin
         step();
         cnt++;
      end
      total_cnt++; if (cnt !== 2) $display("FAIL bp_latency got=%0d exp=2", cnt); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if ({rsp_valid, req_ready, rsp_result, rsp_zf, rsp_sf, rsp_of} !== {2'b10, 32'd0, 3'b100})
            $display("FAIL bp_hold_%0d got=%b%b/%h/%b%b%b exp=10/00000000/100",
                     i, rsp_valid, req_ready, rsp_result, rsp_zf, rsp_sf, rsp_of);
         else pass_cnt++;
         if (i < 3) step();
      end
      rsp_ready = 1'b1;
      step();
      total_cnt++; if ({rsp_valid, req_ready, busy} !== 3'b010)
         $display("FAIL bp_handshake_idle got=%b exp=010", {rsp_valid, req_ready, busy}); else pass_cnt++;
      step();
      req_valid = 1'b0;
      total_cnt++; if ({busy, req_ready} !== 2'b10) $display("FAIL bp_second_accept got=%b exp=10", {busy, req_ready}); else pass_cnt++;
      step();
      total_cnt++; if ({rsp_valid, rsp_result} !== {1'b1, 32'd4})
         $display("FAIL bp_second_result got=%b/%h exp=1/00000004", rsp_valid, rsp_result); else pass_cnt++;
      step();
   endtask

   task automatic test_and_req_change();
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op = 2'd2;
      req_a = 32'hF0F0_F0F0;
      req_b = 32'h0FF0_0FF0;
      step();
      req_valid = 1'b0;
      req_op = 2'd3;
      req_a = 32'hFFFF_FFFF;
      req_b = 32'h1234_5678;
      step();
      total_cnt++; if ({rsp_valid, rsp_result} !== {1'b1, 32'h00F0_00F0})
         $display("FAIL and_result got=%b/%h exp=1/00f000f0", rsp_valid, rsp_result); else pass_cnt++;
      total_cnt++; if ({rsp_zf, rsp_sf, rsp_of} !== 3'b000)
         $display("FAIL and_flags got=%b exp=000", {rsp_zf, rsp_sf, rsp_of}); else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] res;
      logic [2:0]  fl;
      int          lat;
      int          seen;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_op = 2'd1;
      req_a = 32'd7;
      req_b = 32'd2;
      step();
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_mid_req_ready got=%0b exp=0", req_ready); else pass_cnt++;
      step();
      rst = 1'b0;
      total_cnt++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL rst_mid_state got=%b exp=00", {busy, rsp_valid}); else pass_cnt++;
      total_cnt++; if ({rsp_result, rsp_zf, rsp_sf, rsp_of} !== 35'd0)
         $display("FAIL rst_mid_outputs got=%h/%b%b%b exp=0", rsp_result, rsp_zf, rsp_sf, rsp_of); else pass_cnt++;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) seen++;
         step();
      end
      total_cnt++; if (seen !== 0) $display("FAIL rst_mid_no_response got=%0d exp=0", seen); else pass_cnt++;
      run_op(2'd0, 32'd1, 32'd1, res, fl, lat);
      total_cnt++; if ({res, fl} !== {32'd2, 3'b000}) $display("FAIL rst_mid_add got=%h/%b exp=00000002/000", res, fl); else pass_cnt++;
      total_cnt++; if (lat !== 2) $display("FAIL rst_mid_add_latency got=%0d exp=2", lat); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_backpressure();
      test_and_req_change();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
